// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4
//   Scans a 4x4 matrix keypad one column at a time, debounces across whole
//   scans and reports one stable key as a 4-bit code.
//
// Parameters
//   DIV_EXP   : log2 of clocks per column step (scan tick every 2^DIV_EXP clk)
//   DEB_SCANS : consecutive identical full scans to accept a press/release (2..15)
//
// Ports
//   clk       : system clock, rising edge
//   reset     : synchronous, active-low
//   row_in    : keypad rows, active-low, asynchronous (2-FF synchronized)
//   col_out   : column strobe, active-low, one-cold
//   key_code  : accepted key, 4*row + col
//   key_valid : one-cycle pulse on acceptance of a new key
//   key_held  : high from acceptance until the release is debounced
//   multi_key : most recent completed scan saw two or more keys
module keypad_scan_4x4 #(
    parameter int unsigned DIV_EXP   = 17,
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_t;

    localparam logic [3:0] DEB_LIMIT = 4'(DEB_SCANS);

    logic [DIV_EXP-1:0] div_cnt;
    logic               tick;
    logic               eval;
    logic [3:0]         row_meta;
    logic [3:0]         row_sync;
    logic [1:0]         col;
    logic [15:0]        scan_rec;
    logic [15:0]        scan_full;
    logic [4:0]         n_keys;
    logic [3:0]         single_code;
    logic               scan_empty;
    logic               scan_single;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] cand, cand_nxt;
    logic [3:0] code_nxt;
    logic       valid_nxt;
    logic       held_nxt;
    logic       multi_nxt;

    assign tick    = &div_cnt;
    // Evaluation happens on the tick that samples the last column.
    assign eval    = tick && (col == 2'd3);
    assign col_out = ~(4'b0001 << col);

    // Scan record including the column being sampled on this tick, so the
    // evaluation sees all 16 positions in the same cycle.
    always_comb begin
        scan_full = scan_rec;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (col == 2'(c)) begin
                    scan_full[4*r+c] = scan_rec[4*r+c] | ~row_sync[r];
                end
            end
        end
    end

    always_comb begin
        n_keys      = '0;
        single_code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n_keys = n_keys + 5'(scan_full[i]);
            if (scan_full[i]) begin
                single_code = 4'(i);
            end
        end
    end

    assign scan_empty  = (n_keys == 5'd0);
    assign scan_single = (n_keys == 5'd1);

    // Divider, synchronizer, column stepping and scan record.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt  <= '0;
            row_meta <= '1;
            row_sync <= '1;
            col      <= '0;
            scan_rec <= '0;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
            row_meta <= row_in;
            row_sync <= row_meta;
            if (tick) begin
                col      <= col + 2'd1;
                scan_rec <= eval ? '0 : scan_full;
            end
        end
    end

    // Debounce FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cand      <= cand_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_held  <= held_nxt;
            multi_key <= multi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        held_nxt  = key_held;
        multi_nxt = multi_key;
        if (eval) begin
            multi_nxt = (n_keys >= 5'd2);
            case (state)
                IDLE: begin
                    if (scan_single) begin
                        state_nxt = DEB_PRESS;
                        cand_nxt  = single_code;
                        cnt_nxt   = 4'd1;
                    end
                end
                DEB_PRESS: begin
                    if (scan_single) begin
                        if (single_code == cand) begin
                            cnt_nxt = cnt + 4'd1;
                            if (cnt + 4'd1 == DEB_LIMIT) begin
                                state_nxt = HELD;
                                code_nxt  = cand;
                                valid_nxt = 1'b1;
                                held_nxt  = 1'b1;
                            end
                        end else begin
                            cand_nxt = single_code;
                            cnt_nxt  = 4'd1;
                        end
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (scan_empty) begin
                        state_nxt = DEB_REL;
                        cnt_nxt   = 4'd1;
                    end
                end
                DEB_REL: begin
                    if (scan_empty) begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt + 4'd1 == DEB_LIMIT) begin
                            state_nxt = IDLE;
                            held_nxt  = 1'b0;
                        end
                    end else begin
                        state_nxt = HELD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb_keypad_scan_4x4
//   Drives a keypad matrix model (pressed-key mask) against keypad_scan_4x4
//   with DIV_EXP=2 and DEB_SCANS=3, and checks each full scan against a
//   scan-history reference model.
module tb_keypad_scan_4x4;

    localparam int unsigned DEB = 3;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    logic [15:0] pressed;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    // Reference model state: scan classification history since reset
    // (0..15 single key code, 16 empty, 17 multi).
    int unsigned hist[$];
    logic        held_m;
    logic [3:0]  code_m;
    logic        multi_m;

    keypad_scan_4x4 #(
        .DIV_EXP  (2),
        .DEB_SCANS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .multi_key(multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(pressed[4*r +: 4] & ~col_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        held_m  = 1'b0;
        code_m  = 4'd0;
        multi_m = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] mask, output int unsigned acc);
        int unsigned n = 0;
        int unsigned code = 0;
        int unsigned cls;
        bit same;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
                n++;
                code = i;
            end
        end
        cls = (n == 0) ? 16 : ((n == 1) ? code : 17);
        hist.push_back(cls);
        multi_m = (n >= 2);
        acc = 0;
        if (hist.size() >= DEB) begin
            same = 1'b1;
            for (int i = 1; i < DEB; i++) begin
                if (hist[hist.size() - 1 - i] != cls) same = 1'b0;
            end
            if (same && !held_m && cls < 16) begin
                acc    = 1;
                held_m = 1'b1;
                code_m = cls[3:0];
            end else if (same && held_m && cls == 16) begin
                held_m = 1'b0;
            end
        end
    endtask

    // One full scan (16 clk) starting just after an evaluation edge.
    task automatic run_scan(input logic [15:0] mask);
        int unsigned vcount = 0;
        int unsigned cerr = 0;
        int unsigned acc;
        logic [3:0] col_exp;
        pressed = mask;
        for (int j = 1; j <= 16; j++) begin
            step();
            col_exp = ~(4'b0001 << ((j / 4) % 4));
            if (col_out !== col_exp) cerr++;
            if (key_valid === 1'b1) vcount++;
        end
        model_scan(mask, acc);
        check("col_seq", cerr, 0);
        check("valid_pulses", vcount, acc);
        check("key_held", key_held, held_m);
        check("key_code", key_code, code_m);
        check("multi_key", multi_key, multi_m);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, col_out, 4'b1110);
        check({tag, "_code"}, key_code, 4'd0);
        check({tag, "_valid"}, key_valid, 1'b0);
        check({tag, "_held"}, key_held, 1'b0);
        check({tag, "_multi"}, multi_key, 1'b0);
    endtask

    initial begin
        logic [15:0] m;
        logic [15:0] prev;
        int unsigned r;
        int unsigned k;
        int unsigned vpart;

        reset   = 1'b0;
        pressed = '0;
        model_reset();
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b1;

        // Idle: 13 empty scans, column sequence and no pulses.
        repeat (13) run_scan(16'h0000);

        // Bounce: key 9 on scans 1 and 3 only.
        run_scan(16'h0001 << 9);
        run_scan(16'h0000);
        run_scan(16'h0001 << 9);
        run_scan(16'h0000);

        // Clean press of key 9, then held for 10 more scans.
        repeat (3) run_scan(16'h0001 << 9);
        repeat (10) run_scan(16'h0001 << 9);

        // Release with a bounce on the second empty scan.
        run_scan(16'h0000);
        run_scan(16'h0001 << 9);
        repeat (3) run_scan(16'h0000);

        // Multi-key: keys 0 and 5, then only key 0.
        repeat (2) run_scan(16'h0021);
        repeat (3) run_scan(16'h0001);
        repeat (3) run_scan(16'h0000);

        // Randomized scans, biased towards repeats so presses complete.
        prev = '0;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) m = prev;
            else if (r < 6) m = '0;
            else if (r < 8) m = 16'h0001 << $urandom_range(0, 15);
            else m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15)) | 16'($urandom);
            run_scan(m);
            prev = m;
        end
        repeat (3) run_scan(16'h0000);

        // Reset mid-hold with key 15 still pressed.
        repeat (3) run_scan(16'h8000);
        repeat (2) run_scan(16'h8000);
        k = $urandom_range(1, 15);
        vpart = 0;
        for (int j = 0; j < k; j++) begin
            step();
            if (key_valid === 1'b1) vpart++;
        end
        check("partial_valid", vpart, 0);
        reset = 1'b0;
        step();
        check_reset_outputs("midreset");
        reset = 1'b1;
        model_reset();
        repeat (4) run_scan(16'h8000);
        repeat (3) run_scan(16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/keypad_scan_4x4.md
# keypad_scan_4x4

Scanning reader for a 4x4 matrix keypad: the input-side counterpart to the multiplexed 7-segment display driver. It strobes one keypad column at a time, samples the four row lines, debounces across whole scans and reports one stable key as a 4-bit code with a single-cycle valid pulse. Downstream it feeds BCD digit entry into the counter/display datapath; it shares the board clock with the display multiplexer.

## Interface

- DIV_EXP, 17: log2 of clocks per column step. The scan tick fires once every 2^DIV_EXP clocks.
- DEB_SCANS, 4: number of consecutive identical full scans required to accept a press or a release. Legal range 2..15.

- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset. reset==0 at a rising edge resets every register.
- row_in  in  4  keypad rows, active-low with pull-ups. Asynchronous; passes through a 2-FF synchronizer.
- col_out  out  4  column strobe, active-low, one-cold. Column c is driven low as ~(1<<c).
- key_code  out  4  code of the accepted key, = 4*row + col, where row and col are in 0..3.
- key_valid  out  1  one-cycle pulse when a new key is accepted.
- key_held  out  1  high from acceptance until the release is debounced.
- multi_key  out  1  high when the most recent completed scan saw two or more keys.

## Operation

- **Divider:** a DIV_EXP-bit free-running counter. tick=1 when the counter is all ones.
- **Column step, on each tick:**
  - OR the synchronized, inverted rows for the current column into the scan record.
  - Then advance col 0→1→2→3→0.
  - col_out changes on the same edge.
- **Scan evaluation:** happens on the tick that samples column 3. The 16-bit scan record is classified as one of:
  - EMPTY: 0 keys
  - SINGLE: exactly 1 key, with its code
  - MULTI: 2 or more keys
- **Scan record:** cleared after each evaluation. multi_key is updated at every evaluation.
- **FSM states:** IDLE, DEB_PRESS, HELD, DEB_REL. A 4-bit debounce counter and a 4-bit candidate code hold the debounce context.
- **IDLE:**
  - SINGLE → DEB_PRESS, candidate=code, cnt=1.
  - EMPTY or MULTI → stay in IDLE.
- **DEB_PRESS:**
  - SINGLE with the same code → cnt+1.
  - SINGLE with a different code → candidate=new code, cnt=1.
  - EMPTY or MULTI → IDLE.
  - When cnt reaches DEB_SCANS → HELD, key_code<=candidate, key_valid=1 for one cycle, key_held=1.
- **HELD:**
  - EMPTY → DEB_REL, cnt=1.
  - SINGLE (any code) or MULTI → stay in HELD. No new key is reported until release.
- **DEB_REL:**
  - EMPTY → cnt+1. When cnt reaches DEB_SCANS → IDLE, key_held=0.
  - Any non-EMPTY scan → HELD; the count is discarded.
- **Output hold:** key_code keeps its last accepted value after release.

## Timing

- **Reset values:**
  - col_out=4'b1110
  - key_code=0, key_valid=0, key_held=0, multi_key=0
  - divider=0, column index=0, scan record=0, cnt=0, synchronizer=all ones
  - state=IDLE
- **Reset mid-operation:** reset wins over everything. Any press in progress is forgotten. A key still held after reset needs a full new debounce and produces a new key_valid.
- **Tick rate:** first tick after reset falls on clock 2^DIV_EXP. Each full scan takes 4·2^DIV_EXP clocks.
- **Row settling:** each column is sampled 2^DIV_EXP clocks after it was driven. That interval is the settle time and covers the 2-cycle synchronizer latency.
- **Press latency:** a key that is clean from before scan k gives key_valid in the cycle after the evaluation tick of scan k+DEB_SCANS−1.
- **Release latency:** DEB_SCANS empty scans after the first empty scan begins.
- **Pulse width:** key_valid is exactly 1 clk wide, at most once per press.
- **Output registers:** key_held and key_code update on the same edge as key_valid.

## Test plan

All scenarios use DIV_EXP=2 and DEB_SCANS=3, so one tick every 4 clk and one scan every 16 clk.

- **Reset and idle:** hold reset=0 for 3 clk with row_in=4'hF → all outputs at reset values. Then col_out cycles 1110→1101→1011→0111 every 4 clk. No key_valid over 200 clk.
- **Clean press:** assert row 2 (row_in=4'b1011) only while col_out=4'b1101 → after 3 full scans, one key_valid pulse with key_code=9 and key_held=1. No further pulse while the key stays held for 10 more scans.
- **Bounce:**
  - Key 9 present on scans 1 and 3 only, absent on scan 2 → no key_valid.
  - Then 3 consecutive clean scans → key_valid, key_code=9.
- **Release:** from HELD, remove key 9.
  - Present again on the 2nd empty scan → stays HELD.
  - Then 3 clean empty scans → key_held=0, key_code remains 9.
- **Multi-key:** keys 0 and 5 both pressed → multi_key=1 after the first scan, no key_valid, state IDLE. Remove key 5 → key_valid with key_code=0 after 3 scans, and multi_key=0.
- **Reset mid-hold:** key 15 HELD, pulse reset=0 for 1 clk while the key is still pressed → key_held=0 on the next edge. A new key_valid with key_code=15 follows 3 full scans later.
